// File: rtl/key_input_conditioner.sv
// Key front-end: two-flop synchroniser and per-key debounce, producing press/release pulses
// and auto-repeat pulses for held keys. All outputs are registered in the prog_clk domain.
module key_input_conditioner #(
  parameter int unsigned         N_KEYS          = 8,
  parameter int unsigned         DEBOUNCE_CYCLES = 100000,
  parameter int unsigned         REPEAT_DELAY    = 5000000,
  parameter int unsigned         REPEAT_PERIOD   = 1000000,
  parameter logic [N_KEYS-1:0]   REPEAT_MASK     = 8'h0F
) (
  input  logic              prog_clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] raw_keys,
  output logic [N_KEYS-1:0] keys_stable,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic [N_KEYS-1:0] key_event
);

  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  localparam logic [DbW-1:0]  DbLast        = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RepW-1:0] RepDelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepPeriodLast = RepW'(REPEAT_PERIOD - 1);

  typedef enum logic {PhDelay, PhPeriod} phase_e;

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] stable_q, stable_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] repeat_q, repeat_d;
  logic [N_KEYS-1:0] event_q, event_d;

  logic [DbW-1:0]  db_cnt_q  [N_KEYS];
  logic [DbW-1:0]  db_cnt_d  [N_KEYS];
  logic [RepW-1:0] rep_cnt_q [N_KEYS];
  logic [RepW-1:0] rep_cnt_d [N_KEYS];
  phase_e          phase_q   [N_KEYS];
  phase_e          phase_d   [N_KEYS];

  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      db_cnt_d[i]  = db_cnt_q[i];
      rep_cnt_d[i] = rep_cnt_q[i];
      phase_d[i]   = phase_q[i];

      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbLast) begin
        stable_d[i]  = sync2_q[i];
        db_cnt_d[i]  = '0;
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end

      // A stable update (press or release) restarts the repeat timer, which also keeps a
      // release pulse and a repeat pulse off the same edge.
      if (!REPEAT_MASK[i] || press_d[i] || release_d[i] || !stable_q[i]) begin
        rep_cnt_d[i] = '0;
        phase_d[i]   = PhDelay;
      end else if (phase_q[i] == PhDelay && rep_cnt_q[i] == RepDelayLast) begin
        repeat_d[i]  = 1'b1;
        rep_cnt_d[i] = '0;
        phase_d[i]   = PhPeriod;
      end else if (phase_q[i] == PhPeriod && rep_cnt_q[i] == RepPeriodLast) begin
        repeat_d[i]  = 1'b1;
        rep_cnt_d[i] = '0;
      end else begin
        rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
      end
    end
    event_d = press_d | repeat_d;
  end

  always_ff @(posedge prog_clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      event_q   <= '0;
      for (int i = 0; i < int'(N_KEYS); i++) begin
        db_cnt_q[i]  <= '0;
        rep_cnt_q[i] <= '0;
        phase_q[i]   <= PhDelay;
      end
    end else begin
      sync1_q   <= raw_keys;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      event_q   <= event_d;
      for (int i = 0; i < int'(N_KEYS); i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
        phase_q[i]   <= phase_d[i];
      end
    end
  end

  assign keys_stable = stable_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;
  assign key_event   = event_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with short debounce/repeat timings.
module tb_key_input_conditioner;

  logic       prog_clk = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] raw_keys = '0;
  logic [7:0] keys_stable, key_press, key_release, key_repeat, key_event;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = -1;
  int press_cnt [8];
  int rel_cnt   [8];
  int rep_cnt   [8];

  always #5 prog_clk = ~prog_clk;

  key_input_conditioner #(
    .N_KEYS          (8),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .REPEAT_MASK     (8'h0F)
  ) dut (
    .prog_clk    (prog_clk),
    .rst         (rst),
    .raw_keys    (raw_keys),
    .keys_stable (keys_stable),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat),
    .key_event   (key_event)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later, accumulating per-key pulse counts.
  task automatic tick();
    @(posedge prog_clk);
    #1;
    edge_n++;
    for (int i = 0; i < 8; i++) begin
      press_cnt[i] += int'(key_press[i]);
      rel_cnt[i]   += int'(key_release[i]);
      rep_cnt[i]   += int'(key_repeat[i]);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 8; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
      rep_cnt[i]   = 0;
    end
  endtask

  task automatic do_reset();
    raw_keys = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] pack(input logic [7:0] p, input logic [7:0] rl,
                                       input logic [7:0] rp, input logic [7:0] ev,
                                       input logic [7:0] st);
    return {24'h0, p, rl, rp, ev, st};
  endfunction

  logic [7:0] ep, erl, erp, est;

  initial begin
    // Reset state
    tick();
    tick();
    check_eq("reset_outputs", pack(key_press, key_release, key_repeat, key_event, keys_stable),
             64'h0);
    rst = 1'b0;

    // 1. Clean press of key 0, released after edge 6
    do_reset();
    raw_keys = 8'h01;
    edge_n   = -1;
    for (int e = 0; e <= 13; e++) begin
      tick();
      ep  = (e == 5)  ? 8'h01 : 8'h00;
      erl = (e == 12) ? 8'h01 : 8'h00;
      est = (e >= 5 && e < 12) ? 8'h01 : 8'h00;
      check_eq($sformatf("t1_e%0d", e),
               pack(key_press, key_release, key_repeat, key_event, keys_stable),
               pack(ep, erl, 8'h00, ep, est));
      if (e == 6) raw_keys = 8'h00;
    end

    // 2. Glitch on key 1: high for 3 cycles only
    do_reset();
    clear_counts();
    raw_keys = 8'h02;
    est = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      est |= keys_stable;
    end
    raw_keys = 8'h00;
    for (int c = 0; c < 12; c++) begin
      tick();
      est |= keys_stable;
    end
    check_eq("t2_stable_ever", 64'(est), 64'h0);
    check_eq("t2_press_cnt", 64'(press_cnt[1]), 64'd0);
    check_eq("t2_release_cnt", 64'(rel_cnt[1]), 64'd0);

    // 3. Auto-repeat on key 2; release lands where the next repeat would have been
    do_reset();
    raw_keys = 8'h04;
    edge_n   = -1;
    for (int e = 0; e <= 34; e++) begin
      tick();
      ep  = (e == 5) ? 8'h04 : 8'h00;
      erp = (e == 15 || e == 18 || e == 21 || e == 24) ? 8'h04 : 8'h00;
      erl = (e == 27) ? 8'h04 : 8'h00;
      est = (e >= 5 && e < 27) ? 8'h04 : 8'h00;
      check_eq($sformatf("t3_e%0d", e),
               pack(key_press, key_release, key_repeat, key_event, keys_stable),
               pack(ep, erl, erp, ep | erp, est));
      if (e == 21) raw_keys = 8'h00;
    end

    // 4. Non-repeat key 5 held for 40 cycles
    do_reset();
    clear_counts();
    raw_keys = 8'h20;
    for (int c = 0; c < 40; c++) tick();
    raw_keys = 8'h00;
    for (int c = 0; c < 12; c++) tick();
    check_eq("t4_press_cnt", 64'(press_cnt[5]), 64'd1);
    check_eq("t4_release_cnt", 64'(rel_cnt[5]), 64'd1);
    check_eq("t4_repeat_cnt", 64'(rep_cnt[5]), 64'd0);
    check_eq("t4_stable_end", 64'(keys_stable), 64'h0);

    // 5. Keys 0 and 7 together
    do_reset();
    clear_counts();
    raw_keys = 8'h81;
    edge_n   = -1;
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (e == 5) begin
        check_eq("t5_press", 64'(key_press), 64'h81);
        check_eq("t5_event", 64'(key_event), 64'h81);
      end
      if (e == 6) check_eq("t5_event_clear", 64'(key_event), 64'h00);
      if (e == 15) begin
        check_eq("t5_repeat", 64'(key_repeat), 64'h01);
        check_eq("t5_repeat_event", 64'(key_event), 64'h01);
      end
    end
    check_eq("t5_k0_repeats", 64'(rep_cnt[0]), 64'd2);
    check_eq("t5_k7_repeats", 64'(rep_cnt[7]), 64'd0);

    // 6. Reset at edge 12 while key 3 is held
    do_reset();
    raw_keys = 8'h08;
    edge_n   = -1;
    for (int e = 0; e <= 11; e++) begin
      tick();
      if (e == 5) check_eq("t6_first_press", 64'(key_press), 64'h08);
    end
    check_eq("t6_held", 64'(keys_stable), 64'h08);
    rst = 1'b1;
    tick();
    check_eq("t6_reset_outputs", pack(key_press, key_release, key_repeat, key_event, keys_stable),
             64'h0);
    rst = 1'b0;
    for (int e = 13; e <= 32; e++) begin
      tick();
      ep  = (e == 18) ? 8'h08 : 8'h00;
      erp = (e == 28 || e == 31) ? 8'h08 : 8'h00;
      est = (e >= 18) ? 8'h08 : 8'h00;
      check_eq($sformatf("t6_e%0d", e),
               pack(key_press, key_release, key_repeat, key_event, keys_stable),
               pack(ep, 8'h00, erp, ep | erp, est));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
